bcd_updown_counter_n: RTL
=========================

// Module: bcd_updown_counter_n
// PURPOSE
//   Parametrised N-digit packed-BCD up/down counter with a programmable top value,
//   synchronous load, and three run modes: wrap, saturate and ping-pong.
//   It replaces the fixed 2-digit counters used by the PingPongCounter display path.
//   It drives the 7-segment digit decoders and reports boundary events through tc.
// PARAMETERS
//   DIGITS     3                 number of BCD digits; counter width W = 4*DIGITS
//   MAX_VAL    {DIGITS{4'h9}}    top count as packed BCD; every digit <=9; MAX_VAL >= 1
//   RESET_VAL  {W{1'b0}}         count after reset as packed BCD; must be <= MAX_VAL
// PORTS
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous reset, active-high
//   en        in   1   count enable, active-high; one step per enabled cycle
//   up        in   1   direction in wrap/saturate modes: 1=up, 0=down
//   mode      in   2   00=wrap, 01=saturate, 10=ping-pong; 11 behaves as 00
//   load      in   1   synchronous load strobe
//   load_val  in   W   packed-BCD value to load
//   count     out  W   registered packed-BCD count; digit 0 is at [3:0]
//   dir       out  1   effective direction: dir_q in ping-pong mode, otherwise up
//   tc        out  1   registered one-cycle boundary pulse
//   load_err  out  1   registered one-cycle pulse when a load is rejected
// BEHAVIOUR
//   Reset values: count=RESET_VAL, dir_q=1, tc=0, load_err=0.
//   Priority at each clk edge: rst, then load, then en step, then hold.
//   Load:
//     - Accepted when every digit of load_val is <=9 and load_val <= MAX_VAL.
//     - On accept: count <= load_val.
//     - On reject: count is unchanged and load_err=1 on the next cycle.
//     - tc=0 on any load cycle. Load wins over a simultaneous en; no step occurs.
//     - Ping-pong load: load_val==MAX_VAL sets dir_q=0, load_val==0 sets dir_q=1,
//       any other value leaves dir_q unchanged.
//   Step arithmetic:
//     - Per-digit BCD ripple. Up: 9 goes to 0 with carry into the next digit.
//       Down: 0 goes to 9 with borrow from the next digit.
//     - The whole step resolves in one cycle, so latency is 1 clk from en to count.
//   Mode 00 (wrap):
//     - up at MAX_VAL gives 0 and tc=1. down at 0 gives MAX_VAL and tc=1.
//     - Every other step gives tc=0.
//   Mode 01 (saturate):
//     - up at MAX_VAL, or down at 0, holds count and sets tc=1 on every such attempt.
//     - A step that reaches the bound sets tc=1. All other steps give tc=0.
//   Mode 10 (ping-pong):
//     - up is ignored; the step direction is dir_q.
//     - A step whose result is MAX_VAL (dir_q=1) sets dir_q=0 and tc=1 on the same edge.
//     - A step whose result is 0 (dir_q=0) sets dir_q=1 and tc=1 on the same edge.
//     - Defensive case, dir_q=1 at MAX_VAL: count <= MAX_VAL-1, dir_q <= 0, tc=0.
//     - Defensive case, dir_q=0 at 0: count <= 1, dir_q <= 1, tc=0.
//   Outside ping-pong, dir_q <= up every cycle, so entering ping-pong continues in
//   the last requested direction.
//   en=0 with no load: count and dir_q hold, tc=0, load_err=0.
//   A mode change takes effect on the next step. count is never modified by a mode change.
//   Reset asserted mid-count forces the reset values on that same edge.
//   Reset overrides a pending load or step.
//   count never leaves the range [0, MAX_VAL] and never holds a non-BCD digit.
// TESTING (defaults unless stated)
//   rst=1 for 2 clk -> count=12'h000, dir=1, tc=0, load_err=0.
//   Wrap: load 12'h998, then en=1 up=1 for 2 clk -> 12'h999 (tc=0), then 12'h000 (tc=1).
//   Wrap down: load 12'h100, en=1 up=0 -> 12'h099. Load 12'h000, then step -> 12'h999, tc=1.
//   Saturate: load 12'h999, then en=1 up=1 for 3 clk -> count stays 12'h999, tc=1 each cycle.
//   Ping-pong, MAX_VAL=12'h005: en=1 from reset -> 1,2,3,4,5,4,3,2,1,0,1; tc=1 at 5 and 0;
//     dir falls with 5.
//   Loads: 12'h1A3 -> rejected, count unchanged, load_err=1 for 1 clk.
//     load=1 with en=1 and load_val=12'h042 -> 12'h042, no step.
//     rst during run -> RESET_VAL on that same edge.

Source files
------------

// File: rtl/bcd_updown_counter_n_if.sv
// Control and status bundle for the packed-BCD up/down counter.
// The master drives the step/load controls; the slave returns count and boundary events.
interface bcd_updown_counter_n_if #(
  parameter int unsigned W = 12
) ();
  logic         en;
  logic         up;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         dir;
  logic         tc;
  logic         load_err;

  modport master (
    output en, up, mode, load, load_val,
    input  count, dir, tc, load_err
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output count, dir, tc, load_err
  );
endinterface

// File: rtl/bcd_updown_counter_n.sv
// N-digit packed-BCD up/down counter with a programmable top value, synchronous load
// and wrap / saturate / ping-pong run modes.
module bcd_updown_counter_n #(
  parameter int unsigned         DIGITS    = 3,
  parameter logic [4*DIGITS-1:0] MAX_VAL   = {DIGITS{4'h9}},
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_updown_counter_n_if.slave bus_io
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam logic [W-1:0] ZeroVal = '0;
  localparam logic [1:0]  ModeSat  = 2'b01;
  localparam logic [1:0]  ModePing = 2'b10;

  logic [W-1:0] count_q, count_d;
  logic         dir_q, dir_d;
  logic         tc_q, tc_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] count_inc, count_dec;
  logic         at_max, at_zero, load_ok, ping;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign count_inc = bcd_inc(count_q);
  assign count_dec = bcd_dec(count_q);
  assign at_max    = (count_q == MAX_VAL);
  assign at_zero   = (count_q == ZeroVal);
  assign ping      = (bus_io.mode == ModePing);
  // Valid BCD orders the same as binary, so a plain magnitude compare is enough.
  assign load_ok   = bcd_valid(bus_io.load_val) && (bus_io.load_val <= MAX_VAL);

  always_comb begin
    count_d    = count_q;
    dir_d      = dir_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;

    // Tracking up outside ping-pong lets ping-pong resume in the last requested direction.
    if (!ping) dir_d = bus_io.up;

    if (bus_io.load) begin
      if (load_ok) begin
        count_d = bus_io.load_val;
        if (ping) begin
          if (bus_io.load_val == MAX_VAL) begin
            dir_d = 1'b0;
          end else if (bus_io.load_val == ZeroVal) begin
            dir_d = 1'b1;
          end
        end
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus_io.en) begin
      if (ping) begin
        if (dir_q) begin
          if (at_max) begin
            count_d = count_dec;
            dir_d   = 1'b0;
          end else begin
            count_d = count_inc;
            if (count_inc == MAX_VAL) begin
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end
          end
        end else begin
          if (at_zero) begin
            count_d = count_inc;
            dir_d   = 1'b1;
          end else begin
            count_d = count_dec;
            if (count_dec == ZeroVal) begin
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end
          end
        end
      end else if (bus_io.mode == ModeSat) begin
        if (bus_io.up) begin
          if (at_max) begin
            tc_d = 1'b1;
          end else begin
            count_d = count_inc;
            tc_d    = (count_inc == MAX_VAL);
          end
        end else begin
          if (at_zero) begin
            tc_d = 1'b1;
          end else begin
            count_d = count_dec;
            tc_d    = (count_dec == ZeroVal);
          end
        end
      end else begin
        // Wrap mode; mode 11 lands here as well.
        if (bus_io.up) begin
          if (at_max) begin
            count_d = ZeroVal;
            tc_d    = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end else begin
          if (at_zero) begin
            count_d = MAX_VAL;
            tc_d    = 1'b1;
          end else begin
            count_d = count_dec;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= RESET_VAL;
      dir_q      <= 1'b1;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dir_q      <= dir_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus_io.count    = count_q;
  assign bus_io.dir      = ping ? dir_q : bus_io.up;
  assign bus_io.tc       = tc_q;
  assign bus_io.load_err = load_err_q;

endmodule
